// File: rtl/sm_burst_accumulator.sv
// sm_burst_accumulator: folds a burst of sign-magnitude contributions into one
// saturating sign-magnitude sum and presents it with beat count and flags.
module sm_burst_accumulator #(
  parameter int NUMWIDTH  = 16,
  parameter int CNTW      = 8,
  parameter int MAX_BEATS = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUMWIDTH:0]   in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUMWIDTH:0]   out_data,
  output logic [CNTW-1:0]     out_count,
  output logic                out_sat,
  output logic                out_trunc
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUMWIDTH:0]     r_acc;
  logic [CNTW-1:0]       r_cnt;
  logic                  r_sat;
  logic                  r_trunc;

  logic                  w_accept;
  logic                  w_done;
  logic                  w_clear;
  logic [CNTW-1:0]       w_cnt_nxt;
  logic                  w_hit_max;

  logic [NUMWIDTH-1:0]   w_a;
  logic [NUMWIDTH-1:0]   w_b;
  logic                  w_sa;
  logic                  w_sb;
  logic [NUMWIDTH:0]     w_wide;
  logic [NUMWIDTH-1:0]   w_mag;
  logic                  w_sgn;
  logic                  w_beat_sat;
  logic [NUMWIDTH:0]     w_sum;

  assign w_cnt_nxt = r_cnt + CNTW'(1);
  assign w_hit_max = (w_cnt_nxt == CNTW'(MAX_BEATS));

  // Sign-magnitude add of the incoming beat onto the accumulator, saturating.
  always_comb begin
    w_a        = r_acc[NUMWIDTH-1:0];
    w_sa       = r_acc[NUMWIDTH];
    w_b        = in_data[NUMWIDTH-1:0];
    // -0 on the input behaves as +0
    w_sb       = in_data[NUMWIDTH] && (w_b != '0);
    w_wide     = {1'b0, w_a} + {1'b0, w_b};
    w_mag      = '0;
    w_sgn      = 1'b0;
    w_beat_sat = 1'b0;
    if (w_sa == w_sb) begin
      w_sgn = w_sa;
      if (w_wide[NUMWIDTH]) begin
        w_mag      = '1;
        w_beat_sat = 1'b1;
      end else begin
        w_mag = w_wide[NUMWIDTH-1:0];
      end
    end else if (w_a > w_b) begin
      w_sgn = w_sa;
      w_mag = w_a - w_b;
    end else if (w_b > w_a) begin
      w_sgn = w_sb;
      w_mag = w_b - w_a;
    end
    w_sum = {w_sgn && (w_mag != '0), w_mag};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ACCUM: begin
        // ready is held low for the whole time reset is asserted
        in_ready = rst_n;
        w_accept = in_valid && rst_n;
        if (w_accept && (in_last || w_hit_max)) begin
          w_done      = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_clear     = 1'b1;
          w_state_nxt = ACCUM;
        end
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  // Accumulator, beat counter and per-burst flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_trunc <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= w_cnt_nxt;
      r_sat <= r_sat | w_beat_sat;
      if (w_done) r_trunc <= !in_last;
    end else if (w_clear) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_trunc <= 1'b0;
    end
  end

  assign out_data  = r_acc;
  assign out_count = r_cnt;
  assign out_sat   = r_sat;
  assign out_trunc = r_trunc;

endmodule

// File: tb/tb_sm_burst_accumulator.sv
// Directed bench for sm_burst_accumulator: default instance plus a MAX_BEATS=4 one.
module tb_sm_burst_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [16:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready,  out_valid,  out_sat,  out_trunc;
  logic [16:0] out_data;
  logic [7:0]  out_count;
  logic        in_ready4, out_valid4, out_sat4, out_trunc4;
  logic [16:0] out_data4;
  logic [7:0]  out_count4;

  int checks   = 0;
  int failures = 0;

  sm_burst_accumulator #(.NUMWIDTH(16), .CNTW(8), .MAX_BEATS(255)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_sat(out_sat), .out_trunc(out_trunc)
  );

  sm_burst_accumulator #(.NUMWIDTH(16), .CNTW(8), .MAX_BEATS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_count(out_count4), .out_sat(out_sat4), .out_trunc(out_trunc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat for one cycle; assumes the block is ready.
  task automatic beat(input logic [16:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Check the held result, then (out_ready=1) confirm return to ACCUM.
  task automatic expect_burst(input string tag, input logic [16:0] d, input logic [7:0] c,
                              input logic s, input logic t);
    check({tag, ".valid"}, 32'(out_valid), 32'h1);
    check({tag, ".ready"}, 32'(in_ready),  32'h0);
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".count"}, 32'(out_count), 32'(c));
    check({tag, ".sat"},   32'(out_sat),   32'(s));
    check({tag, ".trunc"}, 32'(out_trunc), 32'(t));
    @(posedge clk); #1;
    check({tag, ".released"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst.in_ready",  32'(in_ready),  32'h0);
    check("rst.out_valid", 32'(out_valid), 32'h0);
    check("rst.out_data",  32'(out_data),  32'h0);
    check("rst.out_count", 32'(out_count), 32'h0);
    check("rst.flags",     32'({out_sat, out_trunc}), 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst.release_ready", 32'(in_ready), 32'h1);

    // +5, -3, +10 -> +12
    beat(17'h00005, 1'b0);
    beat(17'h10003, 1'b0);
    beat(17'h0000A, 1'b1);
    expect_burst("mixed", 17'h0000C, 8'd3, 1'b0, 1'b0);

    // saturate then subtract from the clamped magnitude
    beat(17'h0FFF0, 1'b0);
    beat(17'h00020, 1'b0);
    beat(17'h10010, 1'b1);
    expect_burst("sat", 17'h0FFEF, 8'd3, 1'b1, 1'b0);

    // cancellation yields +0
    beat(17'h10007, 1'b0);
    beat(17'h00007, 1'b1);
    expect_burst("cancel", 17'h00000, 8'd2, 1'b0, 1'b0);

    // single beat of -0
    beat(17'h10000, 1'b1);
    expect_burst("negzero", 17'h00000, 8'd1, 1'b0, 1'b0);

    // single negative beat keeps its sign
    beat(17'h10123, 1'b1);
    expect_burst("neg1", 17'h10123, 8'd1, 1'b0, 1'b0);

    // backpressure: result held, pending beat not consumed
    out_ready = 1'b0;
    beat(17'h00002, 1'b0);
    beat(17'h00003, 1'b1);
    in_valid = 1'b1;
    in_data  = 17'h00006;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp.in_ready",  32'(in_ready),  32'h0);
      check("bp.out_valid", 32'(out_valid), 32'h1);
      check("bp.out_data",  32'(out_data),  32'h00005);
      @(posedge clk); #1;
    end
    check("bp.count_held", 32'(out_count), 32'h2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.resume_ready", 32'(in_ready),  32'h1);
    check("bp.resume_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_burst("bp.pending", 17'h00006, 8'd1, 1'b0, 1'b0);

    // MAX_BEATS=4 forced termination
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(17'h00001, 1'b0);
    check("max.valid", 32'(out_valid4), 32'h1);
    check("max.ready", 32'(in_ready4),  32'h0);
    check("max.data",  32'(out_data4),  32'h00004);
    check("max.count", 32'(out_count4), 32'h4);
    check("max.trunc", 32'(out_trunc4), 32'h1);
    check("max.sat",   32'(out_sat4),   32'h0);
    check("max.big_still_accum", 32'({out_valid, in_ready}), 32'b01);
    check("max.big_count", 32'(out_count), 32'h4);

    // reset mid-burst (big) and mid-HOLD (small)
    do_reset();
    beat(17'h00001, 1'b0);
    beat(17'h00001, 1'b0);
    check("mid.partial", 32'(out_count), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.in_ready",   32'(in_ready),   32'h0);
    check("mid.out_valid",  32'(out_valid),  32'h0);
    check("mid.in_ready4",  32'(in_ready4),  32'h0);
    check("mid.out_valid4", 32'(out_valid4), 32'h0);
    check("mid.clear",      32'(out_count),  32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    beat(17'h00009, 1'b1);
    check("post.data4",  32'(out_data4),  32'h00009);
    check("post.count4", 32'(out_count4), 32'h1);
    check("post.trunc4", 32'(out_trunc4), 32'h0);
    expect_burst("post", 17'h00009, 8'd1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
